// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern engine: step modes, direction values
// and the 7-segment constants used by the optional hex readout.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_WALK     = 2'd3
  } mode_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Segments are active-low, ordered {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage

// File: rtl/led_pattern_gen_hex7seg.sv
// hex7seg: 4-bit value to active-low 7-segment pattern, {g,f,e,d,c,b,a}.
// Purely combinational; the caller registers the result.
module hex7seg
  import led_pattern_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_nibble)
      4'h0: o_seg = SEG_ZERO;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: modulus counter / ping-pong / walking-one LED engine with a
// wrap pulse for chaining. Define LED_PATTERN_HEX_EN for the hex0/hex1 readout.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH     = 10,
  parameter int MAX_COUNT = 2**WIDTH - 1
) (
  input  logic             clk_divided,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] leds,
  output logic             wrap,
  output logic             dir
`ifdef LED_PATTERN_HEX_EN
  ,
  output logic [6:0]       hex0,
  output logic [6:0]       hex1
`endif
);

  localparam int POSW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MAXC     = WIDTH'(MAX_COUNT);
  localparam logic [POSW-1:0]  POS_LAST = POSW'(WIDTH - 1);

  logic [WIDTH-1:0] r_cnt;
  logic [POSW-1:0]  r_pos;
  logic             r_dir;
  logic             r_wrap;

  logic [WIDTH-1:0] w_cntNext;
  logic [POSW-1:0]  w_posNext;
  logic             w_dirNext;
  logic             w_wrapNext;

  // Next-state selection; load outranks en, and compares precede the +/-1 so
  // the counter never leaves 0..MAX_COUNT.
  always_comb begin
    w_cntNext  = r_cnt;
    w_posNext  = r_pos;
    w_dirNext  = r_dir;
    w_wrapNext = 1'b0;
    if (load) begin
      w_cntNext = (load_value > MAXC) ? MAXC : load_value;
      w_posNext = '0;
      w_dirNext = DIR_UP;
    end else if (en) begin
      case (mode_e'(mode))
        MODE_UP: begin
          if (r_cnt == MAXC) begin
            w_cntNext  = '0;
            w_wrapNext = 1'b1;
          end else begin
            w_cntNext = r_cnt + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (r_cnt == '0) begin
            w_cntNext  = MAXC;
            w_wrapNext = 1'b1;
          end else begin
            w_cntNext = r_cnt - WIDTH'(1);
          end
        end
        MODE_PINGPONG: begin
          if (r_dir == DIR_UP) begin
            if (r_cnt == MAXC) begin
              w_cntNext  = MAXC - WIDTH'(1);
              w_dirNext  = DIR_DOWN;
              w_wrapNext = 1'b1;
            end else begin
              w_cntNext = r_cnt + WIDTH'(1);
            end
          end else begin
            if (r_cnt == '0) begin
              w_cntNext  = WIDTH'(1);
              w_dirNext  = DIR_UP;
              w_wrapNext = 1'b1;
            end else begin
              w_cntNext = r_cnt - WIDTH'(1);
            end
          end
        end
        MODE_WALK: begin
          if (r_dir == DIR_UP) begin
            if (r_pos == POS_LAST) begin
              w_posNext  = POS_LAST - POSW'(1);
              w_dirNext  = DIR_DOWN;
              w_wrapNext = 1'b1;
            end else begin
              w_posNext = r_pos + POSW'(1);
            end
          end else begin
            if (r_pos == '0) begin
              w_posNext  = POSW'(1);
              w_dirNext  = DIR_UP;
              w_wrapNext = 1'b1;
            end else begin
              w_posNext = r_pos - POSW'(1);
            end
          end
        end
        default: begin
          w_cntNext = r_cnt;
        end
      endcase
    end
  end

  always_ff @(posedge clk_divided) begin
    if (rst) begin
      r_cnt  <= '0;
      r_pos  <= '0;
      r_dir  <= DIR_UP;
      r_wrap <= 1'b0;
    end else begin
      r_cnt  <= w_cntNext;
      r_pos  <= w_posNext;
      r_dir  <= w_dirNext;
      r_wrap <= w_wrapNext;
    end
  end

  always_comb begin
    leds = r_cnt;
    if (mode_e'(mode) == MODE_WALK) begin
      leds = WIDTH'(1) << r_pos;
    end
  end

  assign wrap = r_wrap;
  assign dir  = r_dir;

`ifdef LED_PATTERN_HEX_EN
  // Decode the next count so the registered digits line up with r_cnt.
  localparam int EXTW = (WIDTH < 8) ? 8 : WIDTH;

  logic [EXTW-1:0] w_cntExt;
  logic [6:0]      w_seg0;
  logic [6:0]      w_seg1;
  logic [6:0]      r_hex0;
  logic [6:0]      r_hex1;

  assign w_cntExt = EXTW'(w_cntNext);

  hex7seg u_hexLo (
    .i_nibble (w_cntExt[3:0]),
    .o_seg    (w_seg0)
  );

  hex7seg u_hexHi (
    .i_nibble (w_cntExt[7:4]),
    .o_seg    (w_seg1)
  );

  always_ff @(posedge clk_divided) begin
    if (rst) begin
      r_hex0 <= SEG_ZERO;
      r_hex1 <= SEG_ZERO;
    end else begin
      r_hex0 <= w_seg0;
      r_hex1 <= w_seg1;
    end
  end

  assign hex0 = r_hex0;
  assign hex1 = r_hex1;
`endif

endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern engine for the board display path. It runs in the slow `clk_divided` domain fed by the clock divisor and replaces the plain free-running LED counter. It adds:
- a configurable modulus,
- up, down, ping-pong and walking-one modes,
- synchronous load and enable,
- a wrap/turn pulse for chaining to other display logic.

An optional 7-segment readout is compiled in by macro.

## Interface
Parameters:
- `WIDTH`, 10, counter and LED width (≥2)
- `MAX_COUNT`, 2**WIDTH-1, highest count value in modes 0–2 (1 ≤ MAX_COUNT ≤ 2**WIDTH-1)

Ports:
- `clk_divided`  in  1  block clock
- `rst`  in  1  reset; synchronous, active-high; clock `clk_divided`
- `en`  in  1  advance pattern one step per cycle when high
- `mode`  in  2  0 up, 1 down, 2 ping-pong, 3 walking-one
- `load`  in  1  synchronous load strobe
- `load_value`  in  WIDTH  value written on load
- `leds`  out  WIDTH  pattern output
- `wrap`  out  1  one-cycle pulse on wrap (modes 0/1) or direction turn (modes 2/3)
- `dir`  out  1  current direction, 0 up / 1 down
- `hex0`, `hex1`  out  7  active-low segments of `cnt[3:0]` and `cnt[7:4]`; present only with `LED_PATTERN_HEX_EN`

## Operation
- State registers:
  - `cnt` [WIDTH], counter value
  - `pos` [$clog2(WIDTH)], walking-one position
  - `dir` [1], direction
  - `wrap` [1], registered pulse
- Update priority each edge: `rst` > `load` > `en`. With none asserted, state holds and `wrap` = 0.
- Load:
  - `cnt` ← min(`load_value`, MAX_COUNT); `pos` ← 0; `dir` ← 0; `wrap` ← 0.
  - Takes effect regardless of `en`.
- Mode 0, up: `cnt` ← `cnt`+1. At `cnt`==MAX_COUNT, `cnt` ← 0 and `wrap` ← 1.
- Mode 1, down: `cnt` ← `cnt`−1. At `cnt`==0, `cnt` ← MAX_COUNT and `wrap` ← 1.
- Mode 2, ping-pong:
  - `dir`=0: increment. At MAX_COUNT, `cnt` ← MAX_COUNT−1, `dir` ← 1, `wrap` ← 1.
  - `dir`=1: decrement. At 0, `cnt` ← 1, `dir` ← 0, `wrap` ← 1.
  - With MAX_COUNT=1 the sequence toggles 0,1,0,… with `wrap` set on every step.
- Mode 3, walking-one:
  - `pos` bounces 0…WIDTH−1 using the same turn rule as mode 2, applied to `pos` and WIDTH−1.
  - `cnt` holds.
- Modes 0/1 neither read nor modify `dir`. Modes 0–2 leave `pos` unchanged.
- `leds` is combinational from registers and `mode`:
  - modes 0–2: `leds` = `cnt`
  - mode 3: `leds` = 1<<`pos`
  - A mode change is visible in the same cycle.
- Mode change mid-run:
  - State is retained; the next step applies the new mode rule to the current `cnt`/`pos`/`dir`.
  - `cnt` is always ≤ MAX_COUNT, so no out-of-range state exists.
- All arithmetic is WIDTH bits. `cnt`+1 never overflows because the compare to MAX_COUNT precedes the increment.

## Timing
- Reset values:
  - `cnt`=0, `pos`=0, `dir`=0, `wrap`=0
  - `leds`=0 in modes 0–2 and `leds`=1 in mode 3
  - `hex0`/`hex1`=7'b1000000 (digit 0)
- Latency: one `clk_divided` edge from `en`/`load` sampled high to updated `leds`.
- `wrap` is high for exactly the one cycle following the wrapping/turning edge. Back-to-back `wrap` pulses are legal, e.g. mode 2 with MAX_COUNT=1.
- `load` and `en` asserted together: the load wins and no step occurs that cycle.
- `rst` mid-operation: all state returns to reset values at the next edge; `load` and `en` are ignored that cycle.
- There is no handshake. Inputs are sampled on every edge, and `en` held high steps once per edge.

## Configuration
- `LED_PATTERN_HEX_EN` defined:
  - `hex0`/`hex1` ports exist.
  - Both are registered, updated on the same edge as `cnt`, so they match `cnt` with no extra latency relative to `leds`.
  - Bits above WIDTH−1 read as 0.
- Macro undefined: the `hex0`/`hex1` ports and the decoder logic are absent. The rest of the block is unchanged.

## Structure
- Shared package `led_pattern_pkg`:
  - mode encodings `MODE_UP`, `MODE_DOWN`, `MODE_PINGPONG`, `MODE_WALK`
  - direction constants `DIR_UP`, `DIR_DOWN`
  - the 7-segment blank/zero constants
- One sub-module: `hex7seg`, a 4-bit to active-low 7-segment decoder, instantiated twice under `LED_PATTERN_HEX_EN`.

## Test plan
- Reset then mode 0: WIDTH=4, MAX_COUNT=9, `en`=1 for 11 cycles → `leds` 1…9, 0, 1. `wrap` is high only in the cycle after 9→0.
- Mode 1 from reset, `en`=1 for 2 cycles → `leds` 9, 8. `wrap` is high after the 0→9 step.
- Mode 2, MAX_COUNT=3, 8 steps → `leds` 1,2,3,2,1,0,1,2. `wrap` pulses after the steps to 2 (turn at 3) and to 1 (turn at 0). `dir` toggles at each turn.
- Mode 3, WIDTH=4, 7 steps → `leds` 2,4,8,4,2,1,2.
- `load`=1 with `load_value`=15, MAX_COUNT=9, `en`=1 in the same cycle → `cnt`=9, no step, `wrap`=0. Then assert `rst` mid-run → all outputs return to reset values next edge.
- With `LED_PATTERN_HEX_EN`: load 0x5A (WIDTH=8) → `hex0`=segments for A, `hex1`=segments for 5, same cycle as `leds`=0x5A.
